uart_host_bridge: RTL and testbench

Serial-to-bus debug bridge: a bus initiator on the UART peripheral's CSR port. It polls the UART data register for received bytes and parses fixed-length command frames. It executes each command as a single read or write on a system-bus master port, then returns the result as bytes through the same UART. It lets a host PC peek and poke the SoC address space over the existing serial link without CPU involvement.

---
 rtl/uart_host_bridge_if.sv | 21 ++
 rtl/uart_host_bridge.sv | 148 ++++++++++++++
 tb/tb_uart_host_bridge.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_host_bridge_if.sv
// Simple strobe/acknowledge bus used for both the UART CSR port and the
// system-bus port of the debug bridge. Signal suffixes are from the
// initiator's point of view.
interface uart_host_bridge_if;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        we_o;
  logic        stb_o;
  logic        ack_i;

  modport master (
    output adr_o, dat_o, we_o, stb_o,
    input  dat_i, ack_i
  );

  modport slave (
    input  adr_o, dat_o, we_o, stb_o,
    output dat_i, ack_i
  );
endinterface

// File: rtl/uart_host_bridge.sv
// Serial-to-bus debug bridge. Polls the UART data register for host bytes,
// assembles 'R'/'W' command frames, runs one system-bus access per frame and
// sends the result ('K', 'E' or four read-data bytes) back through the UART.
module uart_host_bridge #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  uart_host_bridge_if.master    u,
  uart_host_bridge_if.master    m,
  output logic                  busy
);

  localparam logic [2:0] POLL   = 3'd0;
  localparam logic [2:0] SAMPLE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] TX     = 3'd3;
  localparam logic [2:0] GAP    = 3'd4;

  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] RSP_K = 8'h4B;
  localparam logic [7:0] RSP_E = 8'h45;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [2:0]  state;
  logic [3:0]  byte_cnt;
  logic        is_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] resp;
  logic [2:0]  resp_left;
  logic [15:0] tmo_cnt;

  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        frame_done;
  logic        unused_dat_bits;

  assign rx_valid        = u.dat_i[8];
  assign rx_byte         = u.dat_i[7:0];
  assign unused_dat_bits = ^u.dat_i[31:9];

  // The byte being sampled completes the frame when it is the last address
  // byte of a read or the last data byte of a write.
  always_comb begin
    frame_done = 1'b0;
    if (!is_write && byte_cnt == 4'd4)
      frame_done = 1'b1;
    if (is_write && byte_cnt == 4'd8)
      frame_done = 1'b1;
  end

  // Main sequencer: poll/sample the UART, execute the bus access, stream the
  // response back with a one-cycle strobe gap between UART writes.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= GAP;
      byte_cnt  <= 4'd0;
      is_write  <= 1'b0;
      addr      <= 32'h0;
      wdata     <= 32'h0;
      resp      <= 32'h0;
      resp_left <= 3'd0;
      tmo_cnt   <= 16'd0;
      busy      <= 1'b0;
    end else begin
      case (state)
        POLL: begin
          if (u.ack_i)
            state <= SAMPLE;
        end
        SAMPLE: begin
          state <= POLL;
          if (rx_valid) begin
            if (byte_cnt == 4'd0) begin
              if (rx_byte == CMD_R || rx_byte == CMD_W) begin
                is_write <= (rx_byte == CMD_W);
                byte_cnt <= 4'd1;
                busy     <= 1'b1;
              end
            end else begin
              if (byte_cnt <= 4'd4)
                addr <= {addr[23:0], rx_byte};
              else
                wdata <= {wdata[23:0], rx_byte};
              if (frame_done) begin
                state   <= EXEC;
                tmo_cnt <= 16'd0;
              end else begin
                byte_cnt <= byte_cnt + 4'd1;
              end
            end
          end
        end
        EXEC: begin
          if (m.ack_i) begin
            state <= TX;
            if (is_write) begin
              resp      <= {RSP_K, 24'h0};
              resp_left <= 3'd1;
            end else begin
              resp      <= m.dat_i;
              resp_left <= 3'd4;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state     <= TX;
            resp      <= {RSP_E, 24'h0};
            resp_left <= 3'd1;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        TX: begin
          if (u.ack_i) begin
            resp      <= {resp[23:0], 8'h0};
            resp_left <= resp_left - 3'd1;
            state     <= GAP;
          end
        end
        GAP: begin
          if (resp_left != 3'd0) begin
            state <= TX;
          end else begin
            busy     <= 1'b0;
            byte_cnt <= 4'd0;
            state    <= POLL;
          end
        end
        default: state <= GAP;
      endcase
    end
  end

  // Strobes decode straight from the state so reset drops them at once.
  always_comb begin
    u.adr_o = 32'h0;
    u.stb_o = (state == POLL) || (state == TX);
    u.we_o  = (state == TX);
    u.dat_o = (state == TX) ? {24'h0, resp[31:24]} : 32'h0;
    m.stb_o = (state == EXEC);
    m.we_o  = (state == EXEC) && is_write;
    m.adr_o = (state == EXEC) ? addr : 32'h0;
    m.dat_o = (state == EXEC) ? wdata : 32'h0;
  end

endmodule

// File: tb/tb_uart_host_bridge.sv
// Bench for uart_host_bridge: behavioural UART (RX queue, TX capture, TX-full
// stall) and system-bus slave (programmable ack delay), driven by a table of
// command frames plus hand-written reset and stall sequences.
module tb_uart_host_bridge;

  logic sys_clk;
  logic sys_rst;
  logic busy;

  uart_host_bridge_if u_if ();
  uart_host_bridge_if m_if ();

  uart_host_bridge #(.TIMEOUT(8)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .u       (u_if),
    .m       (m_if),
    .busy    (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  tx_q[$];
  logic        tx_full   = 1'b0;
  int          ack_delay = 1;
  logic [31:0] rdata     = 32'h0;

  int          m_cnt    = 0;
  int          last_len = 0;
  logic [31:0] last_adr = 32'h0;
  logic [31:0] last_dat = 32'h0;
  logic        last_we  = 1'b0;
  int          gap_err  = 0;
  int          stall_err = 0;
  logic        prev_wr_ack = 1'b0;
  logic        prev_stall  = 1'b0;
  logic [31:0] prev_udat   = 32'h0;
  logic [7:0]  pop_byte;

  typedef struct {
    logic [71:0] frame;
    int          nbytes;
    int          delay;
    logic [31:0] rd;
    logic [31:0] exp_adr;
    logic        exp_we;
    logic [31:0] exp_dat;
    logic [31:0] exp_resp;
    int          exp_n;
    int          exp_len;
  } vec_t;

  vec_t vecs[6];

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  assign u_if.ack_i = u_if.stb_o && (!u_if.we_o || !tx_full);
  assign m_if.ack_i = m_if.stb_o && (ack_delay != 0) && (m_cnt >= ack_delay);
  assign m_if.dat_i = rdata;

  // UART slave read data register: one RX pop per acked read strobe.
  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      u_if.dat_i <= 32'h0;
    end else if (u_if.stb_o && !u_if.we_o && u_if.ack_i) begin
      if (rx_q.size() != 0) begin
        pop_byte = rx_q.pop_front();
        u_if.dat_i <= {23'h0, 1'b1, pop_byte};
      end else begin
        u_if.dat_i <= 32'h0;
      end
    end
  end

  // Mid-cycle monitor: bus strobe length, UART TX capture, gap and stall rules.
  always @(negedge sys_clk) begin
    if (m_if.stb_o) begin
      m_cnt    = m_cnt + 1;
      last_adr = m_if.adr_o;
      last_dat = m_if.dat_o;
      last_we  = m_if.we_o;
    end else begin
      if (m_cnt != 0) last_len = m_cnt;
      m_cnt = 0;
    end
    if (prev_wr_ack && u_if.stb_o) gap_err = gap_err + 1;
    if (prev_stall && !(u_if.stb_o && u_if.we_o && u_if.dat_o == prev_udat))
      stall_err = stall_err + 1;
    if (u_if.stb_o && u_if.we_o && u_if.ack_i) tx_q.push_back(u_if.dat_o[7:0]);
    prev_wr_ack = u_if.stb_o && u_if.we_o && u_if.ack_i;
    prev_stall  = u_if.stb_o && u_if.we_o && !u_if.ack_i;
    prev_udat   = u_if.dat_o;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic release_reset();
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    check_output("rst_busy", {31'h0, busy}, 32'h0);
    @(negedge sys_clk);
    check_output("rst_first_cycle_idle", {31'h0, u_if.stb_o}, 32'h0);
    @(posedge sys_clk);
    #1;
    check_output("rst_first_poll_stb", {31'h0, u_if.stb_o}, 32'h1);
    check_output("rst_first_poll_we", {31'h0, u_if.we_o}, 32'h0);
  endtask

  task automatic apply_stimulus(input logic [71:0] frame, input int nbytes);
    for (int j = 0; j < nbytes; j++) rx_q.push_back(frame[71-8*j -: 8]);
  endtask

  task automatic wait_mstb(input string name);
    for (int c = 0; c < 200 && !m_if.stb_o; c++) @(negedge sys_clk);
    check_output(name, {31'h0, m_if.stb_o}, 32'h1);
  endtask

  task automatic wait_resp(input int base, input int n);
    for (int c = 0; c < 400 && (tx_q.size() - base) < n; c++) @(negedge sys_clk);
    for (int c = 0; c < 50 && busy; c++) @(negedge sys_clk);
    repeat (4) @(negedge sys_clk);
  endtask

  initial begin
    vecs[0] = '{{8'h52, 32'h00001000, 32'h0}, 5, 1, 32'hDEADBEEF,
                32'h00001000, 1'b0, 32'h0, 32'hDEADBEEF, 4, 1};
    vecs[1] = '{{8'h57, 32'h80000004, 32'h12345678}, 9, 2, 32'h0,
                32'h80000004, 1'b1, 32'h12345678, 32'h4B000000, 1, 2};
    vecs[2] = '{{8'h52, 32'h00000040, 32'h0}, 5, 5, 32'hA55A0FF0,
                32'h00000040, 1'b0, 32'h0, 32'hA55A0FF0, 4, 5};
    vecs[3] = '{{8'h52, 32'h00000020, 32'h0}, 5, 0, 32'h0,
                32'h00000020, 1'b0, 32'h0, 32'h45000000, 1, 8};
    vecs[4] = '{{8'h00, 8'hFF, 8'h52, 32'h00000020, 16'h0}, 7, 1, 32'h11223344,
                32'h00000020, 1'b0, 32'h0, 32'h11223344, 4, 1};
    vecs[5] = '{{8'h57, 32'hFFFFFFFC, 32'hCAFEBABE}, 9, 0, 32'h0,
                32'hFFFFFFFC, 1'b1, 32'hCAFEBABE, 32'h45000000, 1, 8};

    sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check_output("reset_u_stb", {31'h0, u_if.stb_o}, 32'h0);
    check_output("reset_m_stb", {31'h0, m_if.stb_o}, 32'h0);
    check_output("reset_u_dat", u_if.dat_o, 32'h0);
    check_output("reset_m_adr", m_if.adr_o, 32'h0);
    release_reset();

    for (int i = 0; i < 6; i++) begin
      int base;
      ack_delay = vecs[i].delay;
      rdata     = vecs[i].rd;
      base      = tx_q.size();
      $display("[TB] vector %0d", i);
      apply_stimulus(vecs[i].frame, vecs[i].nbytes);
      wait_mstb($sformatf("v%0d_mstb_seen", i));
      check_output($sformatf("v%0d_busy_exec", i), {31'h0, busy}, 32'h1);
      wait_resp(base, vecs[i].exp_n);
      check_output($sformatf("v%0d_resp_count", i), tx_q.size() - base, vecs[i].exp_n);
      check_output($sformatf("v%0d_stb_len", i), last_len, vecs[i].exp_len);
      check_output($sformatf("v%0d_adr", i), last_adr, vecs[i].exp_adr);
      check_output($sformatf("v%0d_we", i), {31'h0, last_we}, {31'h0, vecs[i].exp_we});
      if (vecs[i].exp_we) check_output($sformatf("v%0d_wdat", i), last_dat, vecs[i].exp_dat);
      for (int k = 0; k < vecs[i].exp_n && base + k < tx_q.size(); k++)
        check_output($sformatf("v%0d_byte%0d", i, k), {24'h0, tx_q[base+k]},
                     {24'h0, vecs[i].exp_resp[31-8*k -: 8]});
      check_output($sformatf("v%0d_busy_done", i), {31'h0, busy}, 32'h0);
    end

    begin
      int base;
      int se0;
      int c;
      logic [31:0] held;
      $display("[TB] TX stall sequence");
      ack_delay = 1;
      rdata     = 32'h01020304;
      base      = tx_q.size();
      se0       = stall_err;
      tx_full   = 1'b1;
      apply_stimulus({8'h52, 32'h00000100, 32'h0}, 5);
      for (c = 0; c < 300 && !(u_if.stb_o && u_if.we_o); c++) @(negedge sys_clk);
      check_output("stall_started", {31'h0, u_if.stb_o & u_if.we_o}, 32'h1);
      held = u_if.dat_o;
      repeat (50) @(negedge sys_clk);
      check_output("stall_stb", {31'h0, u_if.stb_o}, 32'h1);
      check_output("stall_we", {31'h0, u_if.we_o}, 32'h1);
      check_output("stall_dat", u_if.dat_o, held);
      check_output("stall_first_byte", held, 32'h00000001);
      @(posedge sys_clk);
      #1 tx_full = 1'b0;
      wait_resp(base, 4);
      check_output("stall_resp_count", tx_q.size() - base, 4);
      for (int k = 0; k < 4 && base + k < tx_q.size(); k++)
        check_output($sformatf("stall_byte%0d", k), {24'h0, tx_q[base+k]}, k + 1);
      check_output("stall_stability", stall_err - se0, 0);
    end

    begin
      int base;
      $display("[TB] reset during bus access");
      ack_delay = 0;
      base      = tx_q.size();
      apply_stimulus({8'h52, 32'h00002000, 32'h0}, 5);
      wait_mstb("rstx_mstb_seen");
      repeat (3) @(posedge sys_clk);
      #1 sys_rst = 1'b1;
      #1;
      check_output("rstx_m_stb", {31'h0, m_if.stb_o}, 32'h0);
      check_output("rstx_u_stb", {31'h0, u_if.stb_o}, 32'h0);
      check_output("rstx_busy", {31'h0, busy}, 32'h0);
      repeat (2) @(posedge sys_clk);
      release_reset();
      repeat (20) @(negedge sys_clk);
      check_output("rstx_no_response", tx_q.size() - base, 0);
      check_output("rstx_idle_busy", {31'h0, busy}, 32'h0);
    end

    check_output("uart_write_gap", gap_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
